// File: rtl/tdm_mux41_tx.sv
// Transmit end of a 4-way TDM link: captures channel requests, grants round-robin,
// and holds the granted channel's data plus select code for HOLD_CYCLES cycles.
module tdm_mux41_tx #(
  parameter int WIDTH       = 1,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEn,
  input  logic             iReq0,
  input  logic             iReq1,
  input  logic             iReq2,
  input  logic             iReq3,
  input  logic [WIDTH-1:0] iD0,
  input  logic [WIDTH-1:0] iD1,
  input  logic [WIDTH-1:0] iD2,
  input  logic [WIDTH-1:0] iD3,
  output logic [WIDTH-1:0] oC,
  output logic             oS1,
  output logic             oS0,
  output logic             oValid,
  output logic             oAck0,
  output logic             oAck1,
  output logic             oAck2,
  output logic             oAck3,
  output logic             oBusy,
  output logic             oDbgState
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       pend_q, pend_d;
  logic [1:0]       last_q, last_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [1:0]       s_q, s_d;
  logic             valid_q, valid_d;
  logic [3:0]       ack_q, ack_d;
  logic             busy_q, busy_d;

  logic [3:0]       req;
  logic [3:0]       cand;
  logic [3:0]       gnt_onehot;
  logic [1:0]       gnt_idx;
  logic [1:0]       idx;
  logic             gnt_found;
  logic             grant;
  logic [WIDTH-1:0] gnt_data;

  assign req  = {iReq3, iReq2, iReq1, iReq0};
  assign cand = pend_q | req;

  // Cyclic search starting just after the last granted channel.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    idx       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!gnt_found && cand[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    gnt_data = iD0;
    case (gnt_idx)
      2'd0: gnt_data = iD0;
      2'd1: gnt_data = iD1;
      2'd2: gnt_data = iD2;
      2'd3: gnt_data = iD3;
      default: gnt_data = iD0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iEn && gnt_found) grant = 1'b1;
      end
      HOLD: begin
        // A slot always runs to completion; iEn only gates the next grant.
        if (cnt_q != '0)               cnt_d   = cnt_q - 1'b1;
        else if (iEn && gnt_found)     grant   = 1'b1;
        else                           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d = HOLD;
      cnt_d   = CW'(HOLD_CYCLES - 1);
    end
  end

  // oValid marks every held cycle; oAck pulses only in the first cycle of a slot.
  always_comb begin
    gnt_onehot = grant ? (4'b0001 << gnt_idx) : 4'b0000;
    pend_d     = cand & ~gnt_onehot;
    last_d     = grant ? gnt_idx : last_q;
    c_d        = grant ? gnt_data : c_q;
    s_d        = grant ? gnt_idx : s_q;
    valid_d    = (state_d == HOLD);
    ack_d      = gnt_onehot;
    busy_d     = (state_d != IDLE) || (pend_d != 4'b0000);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 4'b0000;
      last_q  <= 2'd3;
      c_q     <= '0;
      s_q     <= 2'd0;
      valid_q <= 1'b0;
      ack_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      c_q     <= c_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign oC        = c_q;
  assign oS1       = s_q[1];
  assign oS0       = s_q[0];
  assign oValid    = valid_q;
  assign oAck0     = ack_q[0];
  assign oAck1     = ack_q[1];
  assign oAck2     = ack_q[2];
  assign oAck3     = ack_q[3];
  assign oBusy     = busy_q;
  assign oDbgState = state_q;

endmodule

// File: doc/tdm_mux41_tx.md
Name: tdm_mux41_tx

Overview:
- Transmit end of the 4-way time-division link. Samples four request/data channels, arbitrates round-robin, and drives one shared data line plus a 2-bit select code.
- Its outputs oC, oS1 and oS0 connect directly to iC, iS1 and iS0 of the 1-to-4 de-selector at the receive end.
- Each grant holds the line stable for a programmable number of cycles so the de-selector output can settle.

Parameters:
- WIDTH, 1, data width of each channel and of oC.
- HOLD_CYCLES, 4, number of cycles oValid/oC/oS are held per grant; legal range 1..256.

Ports:
- iClk  input  1  rising-edge clock.
- iRst_n  input  1  asynchronous active-low reset.
- iEn  input  1  grant enable; low blocks new grants.
- iReq0..iReq3  input  1 each  channel request; a one-cycle pulse or a level, both accepted.
- iD0..iD3  input  WIDTH each  channel data, sampled at grant.
- oC  output  WIDTH  shared data line.
- oS1, oS0  output  1 each  select code of the channel on oC; {oS1,oS0} = channel index.
- oValid  output  1  high while a slot is being held.
- oAck0..oAck3  output  1 each  one-cycle pulse in the cycle after the channel's data is sampled.
- oBusy  output  1  high when the FSM is not IDLE or any request is pending.

Behaviour:
Decided interface facts:
- One clock, iClk.
- Reset iRst_n is asynchronous and active-low.
- All outputs are registered.

Reset (iRst_n=0, immediate, no clock needed):
- oC=0, oS1=0, oS0=0, oValid=0, oAck*=0, oBusy=0.
- Pending flags = 0.
- Round-robin pointer last=3, so channel 0 has first priority.
- Hold counter = 0; state = IDLE.

Reset mid-hold:
- Slot aborted immediately; outputs forced to reset values.
- All pending requests lost.

Pending capture, every edge:
- req = {iReq3..iReq0}; cand = pending | req.
- pending <= cand & ~grant_onehot.
- A request arriving in the grant cycle of its own channel is consumed by that grant.
- Pending is captured even when iEn=0.

Arbitration:
- Grant the first set bit of cand, searching cyclically from last+1.
- Example: last=1 searches 2, 3, 0, 1.
- last <= granted index.

FSM states:
- IDLE: if iEn & (cand != 0), grant at this edge. Then:
  - oC <= iD[g], {oS1,oS0} <= g, oValid <= 1, oAck[g] <= 1 for the next cycle only.
  - cnt <= HOLD_CYCLES-1; go to HOLD.
  - Otherwise stay in IDLE with oValid=0; oC and oS keep their last values.
- HOLD, cnt != 0: cnt <= cnt-1. oC and oS stable; new requests only pend.
- HOLD, cnt == 0:
  - If iEn & (cand != 0): grant back-to-back at this edge (no idle gap); oValid stays 1, new oC and oS.
  - Otherwise: go to IDLE, oValid <= 0.

iEn behaviour:
- iEn low never truncates a slot in progress.

Timing:
- Latency from request (sampled at edge E, FSM idle) to oValid/oC/oS valid is 1 cycle, i.e. after edge E.
- Each slot lasts exactly HOLD_CYCLES cycles.
- With HOLD_CYCLES=1 and continuous requests, a new channel is granted every cycle.

Counter:
- Width = max(1, $clog2(HOLD_CYCLES)).
- No wrap: the counter only decrements to 0.

oBusy:
- oBusy <= (next_state != IDLE) | (next_pending != 0).

Test Plan:
1. Reset, then iReq0 pulse with iD0=8'hA5 (WIDTH=8, HOLD=4): after the next edge oC=A5, oS=00, oValid=1 for exactly 4 cycles. oAck0 is 1 for the first cycle only, then oValid=0 and oBusy=0.
2. All four iReq pulsed in the same cycle, iD0..3=11,22,33,44: grants follow in order 0,1,2,3, back-to-back, each held 4 cycles. {oS1,oS0} steps 00,01,10,11; oValid stays high for 16 cycles.
3. Fairness: iReq1 and iReq3 held high continuously, HOLD=1: grant sequence 1,3,1,3,... with oAck1 and oAck3 alternating and no idle cycles.
4. iEn=0 while iReq2 is pulsed: no grant, pending retained, oBusy=1. Raise iEn 5 cycles later: channel 2 is granted on the next edge with oS=10.
5. iRst_n dropped asynchronously mid-hold with channel 1 active and channel 3 pending: all outputs 0 immediately, without a clock. After release with no requests, the FSM stays IDLE.
6. HOLD_CYCLES=1: iReq0 granted and iReq0 re-pulsed in its own grant cycle. The re-pulse is consumed and exactly one oAck0 is produced; a re-pulse one cycle later produces a second grant.
